// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the instruction/data requesters, the arbiter and the external memory port.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface mem_bus_arbiter_if #(
    parameter int unsigned WORD_SIZE = 32
);
    logic                 imem_req;
    logic [31:0]          imem_addr;
    logic                 imem_ack;
    logic [WORD_SIZE-1:0] imem_rdata;

    logic                 dmem_req;
    logic                 dmem_we;
    logic [31:0]          dmem_addr;
    logic [WORD_SIZE-1:0] dmem_wdata;
    logic                 dmem_ack;
    logic [WORD_SIZE-1:0] dmem_rdata;

    logic                 bus_err;

    logic [31:0]          mem_addr;
    logic                 en_ext_mem_re;
    logic                 en_ext_mem_wr;
    logic [WORD_SIZE-1:0] data_in;
    logic [WORD_SIZE-1:0] data_out;
    logic                 mem_ready;

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata,
        output bus_err,
        output mem_addr, en_ext_mem_re, en_ext_mem_wr, data_in,
        input  data_out, mem_ready
    );

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata,
        input  bus_err,
        input  mem_addr, en_ext_mem_re, en_ext_mem_wr, data_in,
        output data_out, mem_ready
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one external memory bus between imem and dmem: dmem priority with an imem
// anti-starvation limit, plus a per-transaction timeout that aborts with bus_err.
module mem_bus_arbiter #(
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.slave bus
);

    localparam logic [3:0] StarveMax  = 4'(STARVE_LIMIT);
    localparam logic [7:0] TimeoutEnd = 8'(TIMEOUT - 1);
    localparam bit         TimeoutEn  = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        StIdle,
        StImemOp,
        StDmemOp
    } state_e;

    state_e               state_q;
    logic [3:0]           starve_cnt_q;
    logic [7:0]           wait_cnt_q;
    logic                 we_q;

    logic                 imem_ack_q;
    logic                 dmem_ack_q;
    logic                 bus_err_q;
    logic [WORD_SIZE-1:0] imem_rdata_q;
    logic [WORD_SIZE-1:0] dmem_rdata_q;
    logic [31:0]          mem_addr_q;
    logic                 mem_re_q;
    logic                 mem_wr_q;
    logic [WORD_SIZE-1:0] data_in_q;

    logic imem_elig;
    logic dmem_elig;
    logic grant_imem;
    logic grant_dmem;
    logic timeout_hit;
    logic finish;

    // A port acked this cycle is masked so its stale req cannot re-grant it immediately.
    assign imem_elig   = bus.imem_req & ~imem_ack_q;
    assign dmem_elig   = bus.dmem_req & ~dmem_ack_q;
    assign grant_imem  = imem_elig & (~dmem_elig | (starve_cnt_q == StarveMax));
    assign grant_dmem  = dmem_elig & ~grant_imem;
    assign timeout_hit = TimeoutEn && (wait_cnt_q == TimeoutEnd);
    assign finish      = bus.mem_ready | timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            starve_cnt_q <= 4'd0;
            wait_cnt_q   <= 8'd0;
            we_q         <= 1'b0;
            imem_ack_q   <= 1'b0;
            dmem_ack_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
            mem_addr_q   <= 32'd0;
            mem_re_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            data_in_q    <= '0;
        end else begin
            imem_ack_q <= 1'b0;
            dmem_ack_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (grant_imem) begin
                        state_q      <= StImemOp;
                        starve_cnt_q <= 4'd0;
                        wait_cnt_q   <= 8'd0;
                        mem_addr_q   <= bus.imem_addr;
                        mem_re_q     <= 1'b1;
                        mem_wr_q     <= 1'b0;
                        data_in_q    <= '0;
                    end else if (grant_dmem) begin
                        state_q    <= StDmemOp;
                        wait_cnt_q <= 8'd0;
                        we_q       <= bus.dmem_we;
                        mem_addr_q <= bus.dmem_addr;
                        mem_re_q   <= ~bus.dmem_we;
                        mem_wr_q   <= bus.dmem_we;
                        data_in_q  <= bus.dmem_wdata;
                        if (!bus.imem_req) begin
                            starve_cnt_q <= 4'd0;
                        end else if (starve_cnt_q != StarveMax) begin
                            starve_cnt_q <= starve_cnt_q + 4'd1;
                        end
                    end
                end
                StImemOp, StDmemOp: begin
                    if (finish) begin
                        // mem_ready beats a coincident timeout, so bus_err only on a true abort.
                        state_q    <= StIdle;
                        bus_err_q  <= ~bus.mem_ready;
                        mem_addr_q <= 32'd0;
                        mem_re_q   <= 1'b0;
                        mem_wr_q   <= 1'b0;
                        data_in_q  <= '0;
                        if (state_q == StImemOp) begin
                            imem_ack_q   <= 1'b1;
                            imem_rdata_q <= bus.mem_ready ? bus.data_out : '0;
                        end else begin
                            dmem_ack_q   <= 1'b1;
                            dmem_rdata_q <= (bus.mem_ready && !we_q) ? bus.data_out : '0;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.imem_ack      = imem_ack_q;
    assign bus.imem_rdata    = imem_rdata_q;
    assign bus.dmem_ack      = dmem_ack_q;
    assign bus.dmem_rdata    = dmem_rdata_q;
    assign bus.bus_err       = bus_err_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.en_ext_mem_re = mem_re_q;
    assign bus.en_ext_mem_wr = mem_wr_q;
    assign bus.data_in       = data_in_q;

    ack_exclusive_a: assert property (@(posedge clk) disable iff (rst)
        !(imem_ack_q && dmem_ack_q));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for the key scenarios and a TIMEOUT=0 instance.
module tb_mem_bus_arbiter;

    localparam int STARVE = 4;
    localparam int TMO    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   cmp_en = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.WORD_SIZE(32)) bus ();
    mem_bus_arbiter_if #(.WORD_SIZE(32)) bus0 ();

    mem_bus_arbiter #(.WORD_SIZE(32), .STARVE_LIMIT(STARVE), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_bus_arbiter #(.WORD_SIZE(32), .STARVE_LIMIT(STARVE), .TIMEOUT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: one transaction in flight, owner side, elapsed wait, dmem streak.
    bit          m_busy, m_dside, m_we;
    int          m_waited, m_starve;
    logic [31:0] m_addr, m_din, m_irdata, m_drdata;
    bit          m_re, m_wr, m_iack, m_dack, m_err;
    logic        m_ie, m_de, m_pick_i, m_expire;

    assign m_ie     = bus.imem_req && !m_iack;
    assign m_de     = bus.dmem_req && !m_dack;
    assign m_pick_i = m_ie && (!m_de || (m_starve == STARVE));
    assign m_expire = (TMO != 0) && (m_waited == TMO - 1);

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 0; m_dside <= 0; m_we <= 0; m_waited <= 0; m_starve <= 0;
            m_addr <= 0; m_din <= 0; m_re <= 0; m_wr <= 0;
            m_iack <= 0; m_dack <= 0; m_err <= 0; m_irdata <= 0; m_drdata <= 0;
        end else begin
            m_iack <= 0;
            m_dack <= 0;
            m_err  <= 0;
            if (!m_busy) begin
                if (m_pick_i) begin
                    m_busy <= 1; m_dside <= 0; m_waited <= 0; m_starve <= 0;
                    m_addr <= bus.imem_addr; m_re <= 1; m_wr <= 0; m_din <= 0;
                end else if (m_de) begin
                    m_busy <= 1; m_dside <= 1; m_we <= bus.dmem_we; m_waited <= 0;
                    m_starve <= !bus.imem_req ? 0 : (m_starve < STARVE ? m_starve + 1 : m_starve);
                    m_addr <= bus.dmem_addr; m_re <= !bus.dmem_we; m_wr <= bus.dmem_we;
                    m_din <= bus.dmem_wdata;
                end
            end else if (bus.mem_ready || m_expire) begin
                m_busy <= 0; m_addr <= 0; m_re <= 0; m_wr <= 0; m_din <= 0;
                m_err <= !bus.mem_ready;
                if (m_dside) begin
                    m_dack   <= 1;
                    m_drdata <= (bus.mem_ready && !m_we) ? bus.data_out : 32'd0;
                end else begin
                    m_iack   <= 1;
                    m_irdata <= bus.mem_ready ? bus.data_out : 32'd0;
                end
            end else begin
                m_waited <= (m_waited + 1) % 256;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model imem_ack", bus.imem_ack, m_iack);
            check("model dmem_ack", bus.dmem_ack, m_dack);
            check("model bus_err", bus.bus_err, m_err);
            check("model imem_rdata", bus.imem_rdata, m_irdata);
            check("model dmem_rdata", bus.dmem_rdata, m_drdata);
            check("model mem_addr", bus.mem_addr, m_addr);
            check("model re", bus.en_ext_mem_re, m_re);
            check("model wr", bus.en_ext_mem_wr, m_wr);
            check("model data_in", bus.data_in, m_din);
            check("ack overlap", bus.imem_ack && bus.dmem_ack, 0);
        end
    end

    initial begin
        string seq;
        bit    saw_ack;
        int    ack0;

        bus.imem_req = 0; bus.imem_addr = 0; bus.dmem_req = 0; bus.dmem_we = 0;
        bus.dmem_addr = 0; bus.dmem_wdata = 0; bus.data_out = 0; bus.mem_ready = 0;
        bus0.imem_req = 0; bus0.imem_addr = 0; bus0.dmem_req = 0; bus0.dmem_we = 0;
        bus0.dmem_addr = 0; bus0.dmem_wdata = 0; bus0.data_out = 0; bus0.mem_ready = 0;

        // Reset state
        tick();
        tick();
        cmp_en = 1;
        check("reset imem_ack", bus.imem_ack, 0);
        check("reset mem_addr", bus.mem_addr, 0);
        check("reset re/wr", {bus.en_ext_mem_re, bus.en_ext_mem_wr}, 0);
        check("reset rdata", {bus.imem_rdata, bus.dmem_rdata}, 0);
        rst = 0;

        // Single imem read: ready in cycle 3, ack in cycle 4
        bus.imem_req = 1; bus.imem_addr = 32'h100; bus.data_out = 32'hDEADBEEF;
        tick();
        check("imem c1 addr", bus.mem_addr, 32'h100);
        check("imem c1 re", bus.en_ext_mem_re, 1);
        tick();
        check("imem c2 re", bus.en_ext_mem_re, 1);
        tick();
        check("imem c3 re", bus.en_ext_mem_re, 1);
        bus.mem_ready = 1;
        tick();
        check("imem c4 ack", bus.imem_ack, 1);
        check("imem c4 rdata", bus.imem_rdata, 32'hDEADBEEF);
        check("imem c4 re", bus.en_ext_mem_re, 0);
        bus.imem_req = 0; bus.mem_ready = 0;
        tick();

        // dmem read, then write which must zero dmem_rdata
        bus.dmem_req = 1; bus.dmem_we = 0; bus.dmem_addr = 32'h2004; bus.data_out = 32'hCAFEF00D;
        tick();
        bus.mem_ready = 1;
        tick();
        check("dread ack", bus.dmem_ack, 1);
        check("dread rdata", bus.dmem_rdata, 32'hCAFEF00D);
        bus.dmem_req = 0; bus.mem_ready = 0;
        tick();
        bus.dmem_req = 1; bus.dmem_we = 1; bus.dmem_addr = 32'h2000; bus.dmem_wdata = 32'h12345678;
        tick();
        check("dwrite c1 wr/re", {bus.en_ext_mem_wr, bus.en_ext_mem_re}, 2'b10);
        check("dwrite c1 data_in", bus.data_in, 32'h12345678);
        check("dwrite c1 addr", bus.mem_addr, 32'h2000);
        tick();
        check("dwrite c2 data_in", bus.data_in, 32'h12345678);
        bus.mem_ready = 1;
        tick();
        check("dwrite ack", bus.dmem_ack, 1);
        check("dwrite rdata", bus.dmem_rdata, 0);
        check("dwrite cleared", {bus.en_ext_mem_wr, bus.data_in}, 0);
        bus.dmem_req = 0; bus.dmem_we = 0; bus.mem_ready = 0;
        tick();

        // Timeout abort: ack with bus_err in cycle TMO+1
        bus.imem_req = 1; bus.imem_addr = 32'h300;
        saw_ack = 0;
        for (int c = 1; c <= TMO; c++) begin
            tick();
            if (bus.imem_ack) saw_ack = 1;
        end
        check("timeout early ack", saw_ack, 0);
        check("timeout c8 re", bus.en_ext_mem_re, 1);
        tick();
        check("timeout ack", bus.imem_ack, 1);
        check("timeout bus_err", bus.bus_err, 1);
        check("timeout rdata", bus.imem_rdata, 0);
        bus.imem_req = 0;
        tick();

        // mem_ready on the exact timeout cycle completes normally
        bus.imem_req = 1; bus.imem_addr = 32'h304; bus.data_out = 32'h55AA55AA;
        for (int c = 1; c <= TMO; c++) tick();
        bus.mem_ready = 1;
        tick();
        check("edge ack", bus.imem_ack, 1);
        check("edge bus_err", bus.bus_err, 0);
        check("edge rdata", bus.imem_rdata, 32'h55AA55AA);
        bus.imem_req = 0; bus.mem_ready = 0;
        tick();

        // Reset mid-DMEM_OP drops the transaction
        bus.dmem_req = 1; bus.dmem_addr = 32'h40;
        tick();
        check("pre-reset re", bus.en_ext_mem_re, 1);
        tick();
        rst = 1;
        tick();
        rst = 0; bus.dmem_req = 0;
        check("midreset outputs", {bus.mem_addr, bus.en_ext_mem_re, bus.dmem_ack, bus.bus_err}, 0);
        saw_ack = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.dmem_ack || bus.imem_ack) saw_ack = 1;
        end
        check("midreset no ack", saw_ack, 0);
        bus.imem_req = 1; bus.imem_addr = 32'h80; bus.data_out = 32'h1111; bus.mem_ready = 1;
        tick();
        check("post-reset grant addr", bus.mem_addr, 32'h80);
        tick();
        check("post-reset ack", bus.imem_ack, 1);
        check("post-reset rdata", bus.imem_rdata, 32'h1111);
        bus.imem_req = 0; bus.mem_ready = 0;
        tick();

        // Starvation limit: imem withdraws only during dmem ack cycles
        seq = "";
        bus.dmem_req = 1; bus.dmem_we = 0; bus.dmem_addr = 32'h900; bus.imem_req = 1;
        bus.imem_addr = 32'h500; bus.mem_ready = 1; bus.data_out = 32'h0BADF00D;
        for (int c = 1; c <= 28; c++) begin
            tick();
            if (bus.dmem_ack) seq = {seq, "D"};
            if (bus.imem_ack) seq = {seq, "I"};
            bus.imem_req = !bus.dmem_ack;
        end
        bus.imem_req = 0; bus.dmem_req = 0; bus.mem_ready = 0;
        tests++;
        if (seq != "DDDDIDDDDI") begin
            fails++;
            $display("FAIL starve order: got %s, expected DDDDIDDDDI", seq);
        end
        tick();

        // TIMEOUT=0 instance never aborts
        bus0.imem_req = 1; bus0.imem_addr = 32'h500;
        ack0 = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (bus0.imem_ack || bus0.bus_err) ack0++;
        end
        check("no-timeout acks", ack0, 0);
        check("no-timeout re", bus0.en_ext_mem_re, 1);
        check("no-timeout addr", bus0.mem_addr, 32'h500);

        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single external memory bus between the instruction-side and data-side requesters of the memory system, one transaction at a time. It uses fixed data-side priority with an anti-starvation limit for the instruction side. It also runs a per-transaction timeout so a missing `mem_ready` cannot hang the pipeline. It sits between the two caches/uncached paths and the external memory port.

## Interface
Parameters:
- `WORD_SIZE`, 32, data width.
- `STARVE_LIMIT`, 4, consecutive dmem grants allowed while imem waits (1..15).
- `TIMEOUT`, 64, max cycles waiting for `mem_ready` (0 disables; 1..255).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `imem_req`  in  1  instruction-side read request; held until `imem_ack`.
- `imem_addr`  in  32  instruction read address.
- `imem_ack`  out  1  one-cycle completion pulse.
- `imem_rdata`  out  WORD_SIZE  read data, valid with `imem_ack`.
- `dmem_req`  in  1  data-side request; held until `dmem_ack`.
- `dmem_we`  in  1  1 = write, 0 = read.
- `dmem_addr`  in  32  data address.
- `dmem_wdata`  in  WORD_SIZE  write data.
- `dmem_ack`  out  1  one-cycle completion pulse.
- `dmem_rdata`  out  WORD_SIZE  read data, valid with `dmem_ack` (0 for writes).
- `bus_err`  out  1  high with an ack when that transaction timed out.
- `mem_addr`  out  32  external address.
- `en_ext_mem_re`  out  1  external read enable.
- `en_ext_mem_wr`  out  1  external write enable.
- `data_in`  out  WORD_SIZE  write data to external memory.
- `data_out`  in  WORD_SIZE  read data from external memory.
- `mem_ready`  in  1  external completion, sampled on rising edge.

## Operation
- FSM states are `IDLE`, `IMEM_OP` and `DMEM_OP`; reset enters `IDLE`.
- In `IDLE`, a requester is eligible if its req is high and it was not acked in this cycle (ack-cycle mask).
- Grant rules:
  - Only one requester eligible: grant it.
  - Both eligible: grant dmem, unless `starve_cnt == STARVE_LIMIT`, then grant imem.
- `starve_cnt` (4 bits):
  - Increments on a dmem grant while `imem_req` is high.
  - Clears on an imem grant.
  - Clears on a dmem grant while `imem_req` is low.
  - Saturates at `STARVE_LIMIT`.
- On grant, the same edge registers the external outputs:
  - `mem_addr` gets the granted address.
  - imem grant: `en_ext_mem_re` = 1.
  - dmem grant: `en_ext_mem_re` = ~`dmem_we`, `en_ext_mem_wr` = `dmem_we`, `data_in` = `dmem_wdata`.
  - FSM enters the matching OP state.
  - Request inputs are latched at grant; later changes are ignored until the ack.
- In an OP state, each edge with `mem_ready` = 1:
  - Captures `data_out` into the granted rdata register (writes capture 0).
  - Clears `mem_addr`, `en_ext_mem_re`, `en_ext_mem_wr` and `data_in` to 0.
  - Sets the granted ack for one cycle and returns to `IDLE`.
- Timeout: an 8-bit `wait_cnt` clears on grant and increments in every OP cycle without `mem_ready`.
  - If `TIMEOUT` ≠ 0 and `wait_cnt == TIMEOUT-1` with `mem_ready` low, the transaction aborts.
  - Abort is the same as completion, except rdata = 0 and `bus_err` = 1 with the ack.
- `mem_ready` in the same cycle as the timeout: completion wins, `bus_err` = 0.
- `mem_ready` while in `IDLE` is ignored.
- A requester that drops req mid-transaction is still acked; that ack is discarded by the requester.

## Timing
- Reset (sync, `rst` high at an edge): state `IDLE`, both counters 0, all outputs 0. `rst` has priority over everything, including mid-transaction; the in-flight transaction is dropped with no ack.
- Request high in `IDLE` cycle 0 leads to the OP state and valid external outputs in cycle 1.
- `mem_ready` first seen high at the edge ending cycle k (k ≥ 1) leads to ack, rdata and cleared external outputs in cycle k+1, with FSM in `IDLE` that same cycle.
- Minimum request-to-ack latency is 2 cycles. Back-to-back throughput is one transaction per 2 cycles, because the ack cycle is also the next grant cycle.
- acks, rdata and `bus_err` are registered. rdata holds its value until the next ack of the same port.
- Both acks are never high in the same cycle.

## Test plan
- Reset mid-`DMEM_OP`: after `rst` the FSM is `IDLE`, all outputs 0, no ack issued, and a new `imem_req` is granted normally.
- Single imem read: addr 0x100, `mem_ready` in cycle 3, `data_out` 0xDEADBEEF → `imem_ack` and `imem_rdata` = 0xDEADBEEF in cycle 4, `en_ext_mem_re` high in cycles 1–3 only.
- dmem write: addr 0x2000, wdata 0x12345678 → `en_ext_mem_wr` = 1, `data_in` = 0x12345678 until `mem_ready`; `dmem_rdata` = 0; `dmem_ack` the next cycle.
- Both requesters held high with `mem_ready` always 1 and `STARVE_LIMIT` = 4 → grant order D,D,D,D,I,D,D,D,D,I; acks never overlap and each req holder gets exactly one ack per transaction.
- `TIMEOUT` = 8 and `mem_ready` held 0 → ack with `bus_err` = 1, rdata = 0, and `wait_cnt` reaches 7 at abort. Then `mem_ready` on the exact timeout cycle → normal ack, `bus_err` = 0.
- `TIMEOUT` = 0 and `mem_ready` held low for 300 cycles → no ack; the FSM stays in the OP state.
